// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB
// and drives every datapath strobe and mux select, one instruction per 3-5 cycles.
module multicycle_controller #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero_flag,
  input  logic        branch_taken,
  output logic        mem_write,
  output logic        reg_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        instruction_or_data,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  branch_type,
  output logic [3:0]  alu_control,
  output logic [3:0]  state_out,
  output logic        instr_retired,
  output logic        trap
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] A_PC = 2'b00, A_RS1 = 2'b01, A_OLDPC = 2'b10, A_ZERO = 2'b11;
  localparam logic [1:0] B_RS2 = 2'b00, B_FOUR = 2'b01, B_IMM = 2'b10;
  localparam logic [1:0] R_ALUOUT = 2'b00, R_RDATA = 2'b01, R_ALURES = 2'b10;

  state_t     state;
  logic [6:0] opcode;
  logic       illegal_op;
  logic       unused_bits;

  assign opcode = instr[6:0];
  // zero_flag is informational only; decisions use branch_taken.
  assign unused_bits = ^{zero_flag, instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    case (opcode)
      OP_LOAD, OP_STORE, OP_REG, OP_IMM, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: illegal_op = 1'b0;
      default:                           illegal_op = 1'b1;
    endcase
  end

  // instr[30] selects SUB only for register ops; SRA/SRL honour it for both.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic b30,
                                            input logic is_reg);
    case (f3)
      3'b000:  alu_decode = (is_reg && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_REG:            state <= S_EXECR;
            OP_IMM:            state <= S_EXECI;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            OP_JALR:           state <= S_JALR;
            OP_LUI:            state <= S_LUI;
            OP_AUIPC:          state <= S_ALUWB;
            default:           state <= TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
          endcase
        end
        S_MEMADR:   state <= (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JALR:     state <= S_JAL;
        S_JAL:      state <= S_ALUWB;
        S_LUI:      state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  logic mem_write_s, reg_write_s, ir_write_s, pc_write_s, retired_s, trap_s;

  always_comb begin
    mem_write_s         = 1'b0;
    reg_write_s         = 1'b0;
    ir_write_s          = 1'b0;
    pc_write_s          = 1'b0;
    retired_s           = 1'b0;
    trap_s              = 1'b0;
    instruction_or_data = 1'b0;
    result_src          = R_ALUOUT;
    alu_src_a           = A_PC;
    alu_src_b           = B_RS2;
    alu_control         = ALU_ADD;
    case (state)
      S_FETCH: begin
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
        alu_src_a  = A_PC;
        alu_src_b  = B_FOUR;
        result_src = R_ALURES;
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        retired_s = illegal_op && !TRAP_ON_ILLEGAL;
      end
      S_MEMADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
      end
      S_MEMREAD: instruction_or_data = 1'b1;
      S_MEMWB: begin
        result_src  = R_RDATA;
        reg_write_s = 1'b1;
        retired_s   = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write_s = 1'b1;
        retired_s   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = A_RS1;
        alu_src_b   = B_RS2;
        alu_control = alu_decode(instr[14:12], instr[30], 1'b1);
      end
      S_EXECI: begin
        alu_src_a   = A_RS1;
        alu_src_b   = B_IMM;
        alu_control = alu_decode(instr[14:12], instr[30], 1'b0);
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        retired_s   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = A_RS1;
        alu_src_b   = B_RS2;
        alu_control = ALU_SUB;
        pc_write_s  = branch_taken;
        retired_s   = 1'b1;
      end
      S_JALR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
      end
      // PC takes the target already in alu_out while the ALU forms the link.
      S_JAL: begin
        pc_write_s = 1'b1;
        alu_src_a  = A_OLDPC;
        alu_src_b  = B_FOUR;
      end
      S_LUI: begin
        alu_src_a = A_ZERO;
        alu_src_b = B_IMM;
      end
      S_TRAP:  trap_s = 1'b1;
      default: ;
    endcase
  end

  // Strobes are gated with reset so nothing writes while reset is asserted.
  assign mem_write     = mem_write_s & ~reset;
  assign reg_write     = reg_write_s & ~reset;
  assign ir_write      = ir_write_s  & ~reset;
  assign pc_write      = pc_write_s  & ~reset;
  assign instr_retired = retired_s   & ~reset;
  assign trap          = trap_s      & ~reset;
  assign branch_type   = instr[14:12];
  assign state_out     = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by cycle.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero_flag;
  logic        branch_taken;
  logic        mem_write, reg_write, ir_write, pc_write, instruction_or_data;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  branch_type;
  logic [3:0]  alu_control, state_out;
  logic        instr_retired, trap;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .instr(instr), .zero_flag(zero_flag),
    .branch_taken(branch_taken), .mem_write(mem_write), .reg_write(reg_write),
    .ir_write(ir_write), .pc_write(pc_write), .instruction_or_data(instruction_or_data),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .branch_type(branch_type), .alu_control(alu_control), .state_out(state_out),
    .instr_retired(instr_retired), .trap(trap)
  );

  always #5 clk = ~clk;

  // Strobe vector order: mem_write, reg_write, ir_write, pc_write, iod, instr_retired, trap
  localparam logic [6:0] ST_NONE   = 7'b0000000;
  localparam logic [6:0] ST_FETCH  = 7'b0011000;
  localparam logic [6:0] ST_WB     = 7'b0100010;
  localparam logic [6:0] ST_MEMRD  = 7'b0000100;
  localparam logic [6:0] ST_MEMWR  = 7'b1000010;
  localparam logic [6:0] ST_BR_TK  = 7'b0001010;
  localparam logic [6:0] ST_BR_NT  = 7'b0000010;
  localparam logic [6:0] ST_JAL    = 7'b0001000;
  localparam logic [6:0] ST_TRAP   = 7'b0000001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {mem_write, reg_write, ir_write, pc_write, instruction_or_data, instr_retired, trap};
  endfunction

  // Check state and strobes of the current cycle, then move to the next cycle.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [6:0] stb);
    check({tag, ".state"}, 32'(state_out), 32'(st));
    check({tag, ".strobes"}, 32'(strobes()), 32'(stb));
    @(negedge clk);
    #1;
  endtask

  task automatic load_instr(input logic [31:0] v);
    instr = v;
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    instr        = 32'h00500093;
    zero_flag    = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst.state", 32'(state_out), 32'd0);
    check("rst.strobes", 32'(strobes()), 32'(ST_NONE));
    reset = 1'b0;
    #1;

    // addi x1,x0,5
    check("addi.f.a", 32'(alu_src_a), 32'd0);
    check("addi.f.b", 32'(alu_src_b), 32'd1);
    check("addi.f.rs", 32'(result_src), 32'd2);
    cyc("addi.f", 4'd0, ST_FETCH);
    check("addi.d.a", 32'(alu_src_a), 32'd2);
    check("addi.d.b", 32'(alu_src_b), 32'd2);
    cyc("addi.d", 4'd1, ST_NONE);
    check("addi.e.alu", 32'(alu_control), 32'd0);
    check("addi.e.a", 32'(alu_src_a), 32'd1);
    check("addi.e.b", 32'(alu_src_b), 32'd2);
    cyc("addi.e", 4'd7, ST_NONE);
    check("addi.wb.rs", 32'(result_src), 32'd0);
    cyc("addi.wb", 4'd8, ST_WB);

    // addi with instr[30] set must still ADD
    load_instr(32'h40008093);
    cyc("addi30.f", 4'd0, ST_FETCH);
    cyc("addi30.d", 4'd1, ST_NONE);
    check("addi30.alu", 32'(alu_control), 32'd0);
    cyc("addi30.e", 4'd7, ST_NONE);
    cyc("addi30.wb", 4'd8, ST_WB);

    // sub x2,x1,x2
    load_instr(32'h40208133);
    cyc("sub.f", 4'd0, ST_FETCH);
    cyc("sub.d", 4'd1, ST_NONE);
    check("sub.alu", 32'(alu_control), 32'd1);
    check("sub.a", 32'(alu_src_a), 32'd1);
    check("sub.b", 32'(alu_src_b), 32'd0);
    cyc("sub.e", 4'd6, ST_NONE);
    cyc("sub.wb", 4'd8, ST_WB);

    // sra
    load_instr(32'h4020D133);
    cyc("sra.f", 4'd0, ST_FETCH);
    cyc("sra.d", 4'd1, ST_NONE);
    check("sra.alu", 32'(alu_control), 32'd7);
    cyc("sra.e", 4'd6, ST_NONE);
    cyc("sra.wb", 4'd8, ST_WB);

    // lw
    load_instr(32'h0000A183);
    cyc("lw.f", 4'd0, ST_FETCH);
    cyc("lw.d", 4'd1, ST_NONE);
    check("lw.ma.b", 32'(alu_src_b), 32'd2);
    cyc("lw.ma", 4'd2, ST_NONE);
    check("lw.mr.rs", 32'(result_src), 32'd0);
    cyc("lw.mr", 4'd3, ST_MEMRD);
    check("lw.wb.rs", 32'(result_src), 32'd1);
    cyc("lw.wb", 4'd4, ST_WB);

    // sw
    load_instr(32'h0030A023);
    cyc("sw.f", 4'd0, ST_FETCH);
    cyc("sw.d", 4'd1, ST_NONE);
    cyc("sw.ma", 4'd2, ST_NONE);
    cyc("sw.mw", 4'd5, ST_MEMWR);
    check("sw.back", 32'(state_out), 32'd0);

    // beq taken then not taken
    load_instr(32'h00208463);
    branch_taken = 1'b1;
    cyc("beqt.f", 4'd0, ST_FETCH);
    cyc("beqt.d", 4'd1, ST_NONE);
    check("beqt.rs", 32'(result_src), 32'd0);
    check("beqt.bt", 32'(branch_type), 32'd0);
    check("beqt.alu", 32'(alu_control), 32'd1);
    cyc("beqt.br", 4'd9, ST_BR_TK);
    branch_taken = 1'b0;
    #1;
    cyc("beqn.f", 4'd0, ST_FETCH);
    cyc("beqn.d", 4'd1, ST_NONE);
    cyc("beqn.br", 4'd9, ST_BR_NT);

    // jalr
    load_instr(32'h000080E7);
    cyc("jalr.f", 4'd0, ST_FETCH);
    cyc("jalr.d", 4'd1, ST_NONE);
    cyc("jalr.jr", 4'd11, ST_NONE);
    check("jalr.j.a", 32'(alu_src_a), 32'd2);
    check("jalr.j.b", 32'(alu_src_b), 32'd1);
    cyc("jalr.j", 4'd10, ST_JAL);
    cyc("jalr.wb", 4'd8, ST_WB);

    // lui
    load_instr(32'h123450B7);
    cyc("lui.f", 4'd0, ST_FETCH);
    cyc("lui.d", 4'd1, ST_NONE);
    check("lui.a", 32'(alu_src_a), 32'd3);
    check("lui.b", 32'(alu_src_b), 32'd2);
    cyc("lui.l", 4'd12, ST_NONE);
    cyc("lui.wb", 4'd8, ST_WB);

    // auipc: straight from DECODE to ALUWB
    load_instr(32'h00000097);
    cyc("auipc.f", 4'd0, ST_FETCH);
    cyc("auipc.d", 4'd1, ST_NONE);
    cyc("auipc.wb", 4'd8, ST_WB);

    // reset asserted during MEMREAD of a load
    load_instr(32'h0000A183);
    cyc("lwr.f", 4'd0, ST_FETCH);
    cyc("lwr.d", 4'd1, ST_NONE);
    cyc("lwr.ma", 4'd2, ST_NONE);
    check("lwr.mr.state", 32'(state_out), 32'd3);
    reset = 1'b1;
    #1;
    cyc("lwr.rst0", 4'd0, ST_NONE);
    cyc("lwr.rst1", 4'd0, ST_NONE);
    reset = 1'b0;
    #1;
    cyc("lwr.f2", 4'd0, ST_FETCH);
    cyc("lwr.d2", 4'd1, ST_NONE);

    // illegal opcode: sticky trap until reset
    reset = 1'b1;
    instr = 32'hFFFFFFFF;
    #1;
    reset = 1'b0;
    #1;
    cyc("ill.f", 4'd0, ST_FETCH);
    cyc("ill.d", 4'd1, ST_NONE);
    check("ill.bt", 32'(branch_type), 32'd7);
    for (int i = 0; i < 20; i++) cyc("ill.trap", 4'd15, ST_TRAP);
    reset = 1'b1;
    #1;
    cyc("ill.rst", 4'd0, ST_NONE);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
